// File: rtl/fp32_iterative_divider_if.sv
// Handshake and operand/result bus for fp32_iterative_divider.
// The master drives start/flush/operands; the slave (divider) drives ready/done/result.
interface fp32_iterative_divider_if;
    logic        start;
    logic        flush;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        ready;
    logic        done;
    logic [31:0] result;

    modport master (output start, flush, lhs, rhs, input ready, done, result);
    modport slave  (input start, flush, lhs, rhs, output ready, done, result);
endinterface

// File: rtl/fp32_iterative_divider.sv
// Multi-cycle IEEE-754 binary32 divider: radix-2 restoring recurrence, RNE, subnormals in/out.
// Optional macro FP32_DIV_EARLY_OUT_EN: special-case operands skip DIV/ROUND (done 2 cycles after accept).
module fp32_iterative_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fp32_iterative_divider_if.slave bus
);
    localparam int         DIV_CYCLES = 25 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST   = 5'(DIV_CYCLES - 1);

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 5 && BITS_PER_CYCLE != 25) begin : g_bad_bpc
        $error("fp32_iterative_divider: BITS_PER_CYCLE must be 1, 5 or 25");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (m[i]) n = 5'(23 - i);
        return n;
    endfunction

    // quo = 1 integer, 23 fraction, 1 guard bit; ve <= 0 means the result lands in the subnormal range.
    function automatic logic [31:0] round_pack(input logic [24:0] quo, input logic rem_nz,
                                               input logic signed [9:0] ve, input logic sign);
        logic [24:0]       q_sh, lost_mask, mant_r;
        logic [4:0]        shamt;
        logic signed [9:0] sh_w, exp_w;
        logic              sticky, subn, rup;
        subn      = (ve <= 10'sd0);
        sh_w      = 10'sd1 - ve;
        shamt     = 5'd0;
        if (subn) shamt = (sh_w > 10'sd26) ? 5'd26 : sh_w[4:0];
        lost_mask = ~(25'h1ffffff << shamt);
        sticky    = rem_nz | (|(quo & lost_mask));
        q_sh      = quo >> shamt;
        rup       = q_sh[0] & (sticky | q_sh[1]);
        mant_r    = {1'b0, q_sh[24:1]} + 25'(rup);
        exp_w     = ve + $signed({9'd0, mant_r[24]});
        if (subn) return {sign, 7'd0, mant_r[23], mant_r[22:0]};
        if (exp_w >= 10'sd255) return {sign, 8'hff, 23'd0};
        return {sign, exp_w[7:0], mant_r[22:0]};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       lhs_q, lhs_d, rhs_q, rhs_d;
    logic [25:0]       rem_q, rem_d;
    logic [24:0]       quo_q, quo_d;
    logic [23:0]       mb_q, mb_d;
    logic signed [9:0] ve_q, ve_d;
    logic              spec_q, spec_d, sign_q, sign_d;
    logic [31:0]       spec_res_q, spec_res_d;

    logic [23:0]       a_m, b_m, ma, mb;
    logic [4:0]        a_lz, b_lz;
    logic signed [9:0] va, vb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign, is_spec;
    logic [31:0]       spec_res;
    logic [25:0]       div_r;
    logic [24:0]       div_q;

    // Operand decode: subnormals are normalised so the hidden bit sits at bit 23.
    always_comb begin
        a_m    = {|lhs_q[30:23], lhs_q[22:0]};
        b_m    = {|rhs_q[30:23], rhs_q[22:0]};
        a_lz   = lzc24(a_m);
        b_lz   = lzc24(b_m);
        ma     = a_m << a_lz;
        mb     = b_m << b_lz;
        va     = (lhs_q[30:23] == 8'd0) ? 10'sd1 - $signed({5'd0, a_lz}) : $signed({2'd0, lhs_q[30:23]});
        vb     = (rhs_q[30:23] == 8'd0) ? 10'sd1 - $signed({5'd0, b_lz}) : $signed({2'd0, rhs_q[30:23]});
        a_nan  = (&lhs_q[30:23]) & (|lhs_q[22:0]);
        b_nan  = (&rhs_q[30:23]) & (|rhs_q[22:0]);
        a_inf  = (&lhs_q[30:23]) & ~(|lhs_q[22:0]);
        b_inf  = (&rhs_q[30:23]) & ~(|rhs_q[22:0]);
        a_zero = ~(|lhs_q[30:0]);
        b_zero = ~(|rhs_q[30:0]);
        sign   = lhs_q[31] ^ rhs_q[31];
        is_spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) spec_res = 32'h7fc00000;
        else if (a_inf | b_zero)                                 spec_res = {sign, 8'hff, 23'd0};
        else                                                     spec_res = {sign, 31'd0};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        mb_d       = mb_q;
        ve_d       = ve_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        sign_d     = sign_q;
        div_r      = rem_q;
        div_q      = quo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lhs_d   = bus.lhs;
                    rhs_d   = bus.rhs;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                mb_d       = mb;
                quo_d      = '0;
                cnt_d      = '0;
                spec_d     = is_spec;
                spec_res_d = spec_res;
                sign_d     = sign;
                // Pre-scale the dividend so the quotient always has its integer bit set.
                if (ma < mb) begin
                    rem_d = {1'b0, ma, 1'b0};
                    ve_d  = va - vb + 10'sd126;
                end else begin
                    rem_d = {2'b0, ma};
                    ve_d  = va - vb + 10'sd127;
                end
`ifdef FP32_DIV_EARLY_OUT_EN
                if (is_spec) begin
                    result_d = spec_res;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_DIV;
                end
`else
                state_d = S_DIV;
`endif
            end
            S_DIV: begin
                for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                    if (div_r >= {2'b0, mb_q}) begin
                        div_r = div_r - {2'b0, mb_q};
                        div_q = {div_q[23:0], 1'b1};
                    end else begin
                        div_q = {div_q[23:0], 1'b0};
                    end
                    div_r = div_r << 1;
                end
                rem_d = div_r;
                quo_d = div_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ROUND;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            S_ROUND: begin
                result_d = spec_q ? spec_res_q : round_pack(quo_q, |rem_q, ve_q, sign_q);
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        lhs_q      <= lhs_d;
        rhs_q      <= rhs_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        mb_q       <= mb_d;
        ve_q       <= ve_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
        sign_q     <= sign_d;
    end

    assign bus.ready  = (state_q == S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_fp32_iterative_divider.sv
// Bench for fp32_iterative_divider: directed vector table, handshake/flush/reset sequences,
// and random operands checked against an exact wide-integer division model.
module tb_fp32_iterative_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    fp32_iterative_divider_if bus();

    fp32_iterative_divider #(.BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef FP32_DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 28;
`endif
    localparam int NORM_LAT = 28;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hff) || (a[30:0] == 31'd0) || (b[30:23] == 8'hff) || (b[30:0] == 31'd0);
    endfunction

    // Exact quotient via 64-bit integer division, then IEEE round-to-nearest-even packing.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic            s;
        longint unsigned ma, mb, num, q, rb, half, kept;
        int              ea, eb, scale, p, e_msb, lsb, drop, ef;
        bit              stk, up, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7fc00000;
        if (a_inf || b_zero) return {s, 8'hff, 23'd0};
        if (a_zero || b_inf) return {s, 31'd0};
        ma = {41'd0, a[22:0]};
        ea = -149;
        if (a[30:23] != 0) begin ma = ma + (64'd1 << 23); ea = int'(a[30:23]) - 150; end
        mb = {41'd0, b[22:0]};
        eb = -149;
        if (b[30:23] != 0) begin mb = mb + (64'd1 << 23); eb = int'(b[30:23]) - 150; end
        while (ma < (64'd1 << 23)) begin ma = ma << 1; ea--; end
        while (mb < (64'd1 << 23)) begin mb = mb << 1; eb--; end
        num   = ma << 38;
        q     = num / mb;
        stk   = (num % mb) != 0;
        scale = ea - eb - 38;
        p     = (q >= (64'd1 << 38)) ? 38 : 37;
        e_msb = p + scale;
        lsb   = (e_msb >= -126) ? e_msb - 23 : -149;
        drop  = lsb - scale;
        if (drop > 62) begin
            kept = 0;
        end else begin
            kept = q >> drop;
            rb   = q & ((64'd1 << drop) - 1);
            half = 64'd1 << (drop - 1);
            up   = (rb > half) || ((rb == half) && (stk || kept[0]));
            if (up) kept = kept + 1;
        end
        if (e_msb >= -126) begin
            if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; e_msb++; end
            ef = e_msb + 127;
            if (ef >= 255) return {s, 8'hff, 23'd0};
            return {s, 8'(ef), kept[22:0]};
        end
        return {s, kept[30:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            5: x[30:23] = 8'd0;
            6: x[30:23] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(250, 254));
            7: case ($urandom_range(0, 2))
                   0:       x[30:0]  = '0;
                   1:       x[30:0]  = {8'hff, 23'd0};
                   default: x[30:23] = 8'hff;
               endcase
            8, 9: x[30:23] = 8'($urandom_range(100, 154));
            default: ;
        endcase
        return x;
    endfunction

    // One full operation; returns result, latency (-1 on timeout), ready-high count while busy,
    // and ready in the cycle after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output int lat, output int busy_ready, output int ready_after);
        int guard;
        guard = 0;
        while (!bus.ready && guard < 100) begin @(posedge clk); #1; guard++; end
        bus.lhs   = a;
        bus.rhs   = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        lat        = 1;
        busy_ready = 0;
        while (!bus.done && lat < 60) begin
            if (bus.ready) busy_ready++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.ready) busy_ready++;
        res = bus.result;
        if (!bus.done) lat = -1;
        @(posedge clk); #1;
        ready_after = int'(bus.ready);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, a, b, req;
        int          lat, br, ra, seen;

        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, "6div2"});
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1div3"});
        vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, "m1div3"});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, "1divp0"});
        vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, "m1divp0"});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, "0div0"});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, "infdivinf"});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00400000, "minnorm_div2"});
        vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000, "sub1_div2_tie"});
        vecs.push_back('{32'h00000003, 32'h40000000, 32'h00000002, "sub3_div2_tie"});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, "max_divhalf_ovf"});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_div1"});
        vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, "m0div2"});
        vecs.push_back('{32'h40A00000, 32'hFF800000, 32'h80000000, "5divminf"});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, "minfdiv2"});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, "1div1"});
        vecs.push_back('{32'h00000001, 32'h3F000000, 32'h00000002, "sub1_divhalf"});
        vecs.push_back('{32'h3F800000, 32'h00000001, 32'h7F800000, "1div_sub1_ovf"});

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.lhs   = '0;
        bus.rhs   = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, res, lat, br, ra);
            check({vecs[i].name, "_res"}, res, vecs[i].q);
            check({vecs[i].name, "_lat"}, 32'(lat),
                  32'(is_special(vecs[i].a, vecs[i].b) ? SPEC_LAT : NORM_LAT));
            check({vecs[i].name, "_ready_busy"}, 32'(br), 32'd0);
            check({vecs[i].name, "_ready_after"}, 32'(ra), 32'd1);
        end

        // start held high across a busy operation: second op taken only after done.
        bus.lhs   = 32'h40C00000;
        bus.rhs   = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.lhs = 32'h3F800000;
        bus.rhs = 32'h40400000;
        lat = 1;
        while (!bus.done && lat < 60) begin @(posedge clk); #1; lat++; end
        check("hold_first_lat", 32'(lat), 32'd28);
        check("hold_first_res", bus.result, 32'h40400000);
        @(posedge clk); #1;
        check("hold_ready_after_done", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("hold_second_accepted", 32'(bus.ready), 32'd0);
        lat = 1;
        while (!bus.done && lat < 60) begin @(posedge clk); #1; lat++; end
        check("hold_second_lat", 32'(lat), 32'd28);
        check("hold_second_res", bus.result, 32'h3EAAAAAB);
        @(posedge clk); #1;

        // Flush in cycle 10 of an operation.
        bus.lhs   = 32'h40C00000;
        bus.rhs   = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (lat < 10) begin @(posedge clk); #1; lat++; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_ready_next", 32'(bus.ready), 32'd1);
        check("flush_done_low", 32'(bus.done), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.done) seen++; end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result_kept", bus.result, 32'h3EAAAAAB);

        // flush and start together: nothing accepted.
        bus.lhs   = 32'h40C00000;
        bus.rhs   = 32'h40000000;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_not_accepted", 32'(bus.ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 35; k++) begin @(posedge clk); #1; if (bus.done) seen++; end
        check("flush_start_no_done", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of DIV.
        bus.lhs   = 32'h40C00000;
        bus.rhs   = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ready", 32'(bus.ready), 32'd1);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h40C00000, 32'h40000000, res, lat, br, ra);
        check("after_reset_res", res, 32'h40400000);
        check("after_reset_lat", 32'(lat), 32'd28);

        for (int i = 0; i < 250; i++) begin
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, res, lat, br, ra);
            req = model_div(a, b);
            check($sformatf("rand%0d_res %h/%h", i, a, b), res, req);
            check($sformatf("rand%0d_lat %h/%h", i, a, b), 32'(lat),
                  32'(is_special(a, b) ? SPEC_LAT : NORM_LAT));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fp32_iterative_divider.md
Name: fp32_iterative_divider

Overview:
- Multi-cycle IEEE-754 binary32 divider (lhs / rhs), the division counterpart to the pipelined FP32 multiplier in the FPU.
- Sits beside the multiplier in the FP execution unit; one operation in flight, start/ready/done handshake.
- Uses radix-2 restoring digit recurrence with full subnormal input/output support.
- Rounding is fixed to round-to-nearest-even; exception flags are not produced.

Parameters:
- BITS_PER_CYCLE, default 1: quotient bits retired per DIV cycle. Legal values 1, 5, 25 (must divide 25). Any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when start && ready && !flush.
- flush  input  1  synchronous abort of any in-flight operation.
- lhs  input  32  dividend, sampled at accept.
- rhs  input  32  divisor, sampled at accept.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  32  quotient; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ready=1, done=0, result=32'h0, iteration counter=0.
- States:
  - IDLE: on accept, capture operands and go to PREP.
  - PREP: decode special cases; normalise subnormal mantissas by leading-zero shift; virtual exponents va/vb as 10-bit signed. If ma<mb, shift dividend left 1 and decrement the exponent. ve=va-vb+127. Go to DIV.
  - DIV: 25/BITS_PER_CYCLE cycles; each cycle produces BITS_PER_CYCLE quotient bits (1 integer, 23 fraction, 1 guard). Go to ROUND.
  - ROUND: sticky = (remainder != 0). If ve<=0, right-shift the quotient by 1-ve, saturating at 26, with shifted-out bits ORed into sticky; result exponent field 0. Round to nearest even. Rounding carry into the hidden bit raises the exponent: subnormal becomes 1; normal becomes e+1. Exponent >= 255 gives inf. Register result, assert done for 1 cycle, return to IDLE.
- Latency: done rises exactly 3+25/BITS_PER_CYCLE cycles after the accept edge (28 at default). Latency is fixed for every operand class unless the optional feature is enabled.
- Throughput: ready is low from PREP through ROUND, and rises in the cycle after the done cycle. start while busy is ignored, not queued.
- Special cases, decided in PREP and overriding datapath output at ROUND:
  - sign = lhs[31]^rhs[31] for all non-NaN results.
  - NaN input, 0/0, or inf/inf gives 32'h7fc00000 (canonical qNaN, sign 0).
  - inf/finite or finite-nonzero/0 gives {sign, 8'hff, 23'h0}.
  - 0/nonzero or finite/inf gives {sign, 31'h0}.
- Flush: in any state, next state is IDLE; done is not asserted for the aborted op; result is unchanged. flush and start in the same cycle: flush wins, nothing accepted.
- Reset mid-operation: immediately returns to reset state; no done.
- Width rules:
  - Exponent arithmetic is 10-bit two's complement. Underflow shift compares signed. Overflow check uses ve+carry >= 255 signed.
  - Remainder register is 26 bits wide to hold 2*mb.

Optional Feature:
- FP32_DIV_EARLY_OUT_EN:
  - Defined: a special-case operation (NaN, inf, zero operand) skips DIV and ROUND; PREP goes straight to DONE, so done rises 2 cycles after accept.
  - Undefined: special cases traverse all states with fixed latency 3+25/BITS_PER_CYCLE.
  - Normal operands have identical latency in both builds.

Test Plan:
- 6.0/2.0: lhs=32'h40C00000, rhs=32'h40000000 -> result 32'h40400000; done exactly 28 cycles after accept; ready low for cycles 1-28.
- 1.0/3.0: 32'h3F800000 / 32'h40400000 -> 32'h3EAAAAAB (round up on guard+sticky). -1.0/3.0 -> 32'hBEAAAAAB.
- Specials: 1.0/+0 -> 32'h7F800000; -1.0/+0 -> 32'hFF800000; 0/0 -> 32'h7FC00000; 32'h7F800000/32'h7F800000 -> 32'h7FC00000. Each at latency 28, or 2 with FP32_DIV_EARLY_OUT_EN.
- Subnormal/boundary:
  - 32'h00800000 / 2.0 -> 32'h00400000.
  - 32'h00000001 / 2.0 -> 32'h00000000 (tie to even).
  - 32'h00000003 / 2.0 -> 32'h00000002 (tie to even).
  - 32'h7F7FFFFF / 0.5 (32'h3F000000) -> 32'h7F800000.
- Handshake: start held high through a busy operation -> only the first op accepted, the second accepted in the cycle after done; flush in cycle 10 -> no done, ready=1 next cycle, result retains previous value.
- Reset: deassert rst_n asynchronously mid-DIV -> ready=1, done=0, result=0 immediately; a following 6.0/2.0 completes normally.
